wfg_record_spi: RTL and testbench
=================================

# wfg_record_spi

SPI capture receiver for the waveform generator: the receiving end of the `wfg_drive_spi` output. It samples an external SPI link (SCLK, CS_N, SDI) in the Wishbone clock domain and deserializes frames into words of 1–32 bits. Completed words go onto an AXI-stream master port as a new stimulus source for the interconnect. Configuration and status use the standard per-block Wishbone slave, with a 4-bit local address.

## Interface
- Parameters:
  - `FIFO_DEPTH`, default 2: depth of the output word buffer (power of two, ≥2).
- Ports:
  - `wb_clk_i` in, 1: sole clock; SPI inputs are asynchronous to it.
  - `wb_rst_i` in, 1: reset, synchronous, active-high.
  - `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` in, 1 each: Wishbone strobe, cycle and write-enable.
  - `wbs_sel_i` in, 4: byte selects; ignored, full-word access only.
  - `wbs_adr_i` in, 32: only bits [3:2] are decoded.
  - `wbs_dat_i` in, 32: write data.
  - `wbs_ack_o` out, 1: acknowledge.
  - `wbs_dat_o` out, 32: read data.
  - `spi_sclk_i`, `spi_cs_ni`, `spi_sdi_i` in, 1 each: external SPI clock, active-low chip select, serial data.
  - `wfg_axis_tready_i` in, 1: downstream ready.
  - `wfg_axis_tvalid_o` out, 1: output word valid.
  - `wfg_axis_tdata_o` out, 32: output word, right-justified and zero-extended.

## Operation
- Registers (byte offsets):
  - 0x0 CTRL [0] `en`, [1] `cpol`, [2] `lsb_first`; reset 0.
  - 0x4 CFG [4:0] `wlen` = word length − 1; reset 0x1F, i.e. 32-bit words.
  - 0x8 STATUS [0] `ovf`, sticky, write 1 to clear; [1] `busy`, read-only; [3:2] FIFO level, read-only.
  - 0xC CNT [15:0], only with the counter macro (see Configuration); any write clears it.
- Input conditioning: each SPI input passes through a 2-flop synchronizer, followed by one history flop for edge detection.
- The sample edge is the synchronized rising edge of `sclk ^ cpol`.
- Receive FSM:
  - IDLE → SHIFT when `en` is set and a CS_N falling edge is detected. Entering SHIFT clears the shift register and sets the bit counter to 0.
  - In SHIFT, each sample edge shifts in SDI: MSB-first by default, LSB-first when `lsb_first` is set. The bit counter then increments.
  - When the counter reaches `wlen` on a sample edge, that bit completes the word. The word is pushed to the FIFO, the counter returns to 0 and the FSM stays in SHIFT, so consecutive words can share one CS assertion.
  - CS_N going high while in SHIFT returns the FSM to IDLE and discards any partial word.
  - Clearing `en` forces IDLE and discards the partial word. FIFO contents are kept.
- Word alignment: words shorter than 32 bits are right-justified and zero-extended. With MSB-first order, the first bit received lands in bit `wlen`.
- Overflow: if a word completes while the FIFO is full, the word is dropped and `ovf` is set. The FIFO contents are unchanged.
- Software writes to CFG or CTRL take effect at the next CS assertion. Changing them mid-frame is undefined.
- `busy` = FSM in SHIFT.

## Timing
- Reset values: `wbs_ack_o`=0, `wbs_dat_o`=0, `wfg_axis_tvalid_o`=0, `wfg_axis_tdata_o`=0. FSM is in IDLE, FIFO is empty, `ovf`=0.
- Wishbone:
  - `wbs_ack_o` is registered and pulses for one cycle, the cycle after `stb & cyc` is seen while ack is low. Ack is never held asserted for two consecutive cycles.
  - Read data is valid while ack is high.
- AXIS:
  - `wfg_axis_tvalid_o` = FIFO not empty; `wfg_axis_tdata_o` = FIFO head.
  - A word pops on `tvalid & tready`.
  - Once valid, tdata is stable until the transfer.
- Latency: the FIFO is written 1 cycle after the synchronized completing sample edge, and `tvalid` rises on the following cycle. That is 4 `wb_clk_i` cycles after the raw SCLK edge.
- Simultaneous push and pop when the FIFO is full: the pop is honoured first, so the push succeeds and `ovf` is not set.
- Clear `ovf` while a new overflow occurs in the same cycle: `ovf` stays set.
- Maximum SCLK frequency is `wb_clk_i`/4. SCLK high and low times must each be at least 2 `wb_clk_i` cycles.
- Reset mid-frame: all state returns to reset values in the cycle after `wb_rst_i` is sampled high.

## Configuration
- `WFG_RECORD_SPI_CNT_EN`
  - Defined: a 16-bit counter of words pushed into the FIFO (dropped words are not counted). It wraps from 0xFFFF to 0 and is readable at 0xC; any write clears it.
  - Undefined: no counter hardware; 0xC reads 0 and writes are acked and ignored.

## Structure
- Shared package `wfg_record_spi_pkg`:
  - register offset constants;
  - CTRL bit-index constants;
  - FSM state enum {IDLE, SHIFT}.
- AXIS signals use the existing `axis_t` bundle at integration.
- Sub-module `wfg_record_spi_fifo`: synchronous FIFO with `FIFO_DEPTH` entries and 32-bit width. It provides push/pop, full/empty and a level output, and implements pop-before-push when full.

## Test plan
- Mode 0 (`cpol`=0, MSB-first), `wlen`=31, send 0xDEADBEEF with tready=1 → one AXIS beat with tdata 0xDEADBEEF; CNT=1.
- `wlen`=7, `lsb_first`=1, send bits 1,0,1,1,0,0,0,0 → tdata 0x0000000D.
- `wlen`=7, tready=0, send 3 bytes 0x11, 0x22, 0x33 in one CS → FIFO holds 0x11 and 0x22; `ovf`=1. Writing 1 to STATUS[0] clears `ovf`. Then tready=1 → beats 0x11 then 0x22.
- Raise CS_N after 5 bits of a 32-bit word → no beat; `busy`=0; the next full frame 0x12345678 is received intact.
- `cpol`=1, idle SCLK high, send 0xA5 with `wlen`=7 → tdata 0xA5.
- Assert `wb_rst_i` mid-frame with one word in the FIFO → tvalid=0, CTRL=0, CFG=0x1F. Each Wishbone read afterwards gets a single 1-cycle ack.

Source files
------------

// File: rtl/wfg_record_spi_pkg.sv
// Shared definitions for the SPI capture receiver: register map, CTRL bit
// positions and receive FSM states.
package wfg_record_spi_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_CFG    = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_CNT    = 2'd3;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_CPOL      = 1;
    localparam int CTRL_LSB_FIRST = 2;

    localparam logic [4:0] WLEN_RESET = 5'd31;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/wfg_record_spi_fifo.sv
// Synchronous 32-bit word FIFO; a pop in the same cycle frees room for a push
// even when full.
module wfg_record_spi_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [31:0]              wr_data,
    output logic [31:0]              rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign level   = count;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Present zero when empty so the stream data idles at a known value.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wfg_record_spi.sv
// SPI capture receiver: deserializes 1-32 bit words into an AXI-stream source.
// Optional word counter at 0xC is built when WFG_RECORD_SPI_CNT_EN is defined.
//
//   state | meaning
//   IDLE  | waiting for a CS_N falling edge while enabled
//   SHIFT | frame active, shifting SDI on each sample edge
module wfg_record_spi
    import wfg_record_spi_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        spi_sclk_i,
    input  logic        spi_cs_ni,
    input  logic        spi_sdi_i,
    input  logic        wfg_axis_tready_i,
    output logic        wfg_axis_tvalid_o,
    output logic [31:0] wfg_axis_tdata_o
);

    logic        ctrl_en, ctrl_cpol, ctrl_lsb;
    logic [4:0]  cfg_wlen;
    logic        ovf;
    logic [2:0]  sclk_sr, cs_sr;
    logic [1:0]  sdi_sr;
    logic        sample, cs_fall, cs_rise, sdi;
    state_t      state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d, wlen_q, wlen_d;
    logic        lsb_q, lsb_d, done_q, done_d;
    logic [31:0] sh_q, sh_d, word_q, word_d, shifted;
    logic        wb_req, wb_wr, ovf_clr, ovf_set, axis_pop, push_ok;
    logic [1:0]  addr;
    logic [31:0] rd_data, cnt_rd, level_ext;
    logic        fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic        unused_ok;

    assign unused_ok = ^{wbs_sel_i, wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i[31:5], level_ext[31:2]};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sclk_sr <= '0;
            cs_sr   <= '1;
            sdi_sr  <= '0;
        end else begin
            sclk_sr <= {sclk_sr[1:0], spi_sclk_i};
            cs_sr   <= {cs_sr[1:0], spi_cs_ni};
            sdi_sr  <= {sdi_sr[0], spi_sdi_i};
        end
    end

    assign sample  = (sclk_sr[1] ^ ctrl_cpol) & ~(sclk_sr[2] ^ ctrl_cpol);
    assign cs_fall = cs_sr[2] & ~cs_sr[1];
    assign cs_rise = ~cs_sr[2] & cs_sr[1];
    assign sdi     = sdi_sr[1];

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            sh_q      <= '0;
            word_q    <= '0;
            done_q    <= 1'b0;
            wlen_q    <= WLEN_RESET;
            lsb_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sh_q      <= sh_d;
            word_q    <= word_d;
            done_q    <= done_d;
            wlen_q    <= wlen_d;
            lsb_q     <= lsb_d;
        end
    end

    // Word length and bit order are captured at CS assertion and held for the frame.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sh_d      = sh_q;
        word_d    = word_q;
        done_d    = 1'b0;
        wlen_d    = wlen_q;
        lsb_d     = lsb_q;
        shifted   = sh_q;
        if (lsb_q) shifted[bit_cnt_q] = sdi;
        else       shifted = {sh_q[30:0], sdi};

        if (!ctrl_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_d   = SHIFT;
                        bit_cnt_d = '0;
                        sh_d      = '0;
                        wlen_d    = cfg_wlen;
                        lsb_d     = ctrl_lsb;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state_d = IDLE;
                    end else if (sample) begin
                        if (bit_cnt_q == wlen_q) begin
                            done_d    = 1'b1;
                            word_d    = shifted;
                            sh_d      = '0;
                            bit_cnt_d = '0;
                        end else begin
                            sh_d      = shifted;
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign axis_pop = wfg_axis_tvalid_o & wfg_axis_tready_i;
    assign push_ok  = done_q & (~fifo_full | axis_pop);
    assign ovf_set  = done_q & fifo_full & ~axis_pop;

    wfg_record_spi_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .push    (done_q),
        .pop     (axis_pop),
        .wr_data (word_q),
        .rd_data (wfg_axis_tdata_o),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign wfg_axis_tvalid_o = ~fifo_empty;
    assign level_ext         = 32'(fifo_level);

    assign wb_req  = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
    assign wb_wr   = wb_req & wbs_we_i;
    assign addr    = wbs_adr_i[3:2];
    assign ovf_clr = wb_wr && (addr == ADDR_STATUS) && wbs_dat_i[0];

`ifdef WFG_RECORD_SPI_CNT_EN
    logic [15:0] word_cnt;
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)                            word_cnt <= '0;
        else if (wb_wr && (addr == ADDR_CNT))    word_cnt <= '0;
        else if (push_ok)                        word_cnt <= word_cnt + 16'd1;
    end
    assign cnt_rd = {16'b0, word_cnt};
`else
    logic unused_push;
    assign unused_push = push_ok;
    assign cnt_rd      = '0;
`endif

    always_comb begin
        rd_data = '0;
        case (addr)
            ADDR_CTRL:   rd_data = {29'b0, ctrl_lsb, ctrl_cpol, ctrl_en};
            ADDR_CFG:    rd_data = {27'b0, cfg_wlen};
            ADDR_STATUS: rd_data = {28'b0, level_ext[1:0], (state_q == SHIFT), ovf};
            default:     rd_data = cnt_rd;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            ctrl_en   <= 1'b0;
            ctrl_cpol <= 1'b0;
            ctrl_lsb  <= 1'b0;
            cfg_wlen  <= WLEN_RESET;
            ovf       <= 1'b0;
        end else begin
            wbs_ack_o <= wb_req;
            wbs_dat_o <= wb_req ? rd_data : '0;
            if (wb_wr && (addr == ADDR_CTRL)) begin
                ctrl_en   <= wbs_dat_i[CTRL_EN];
                ctrl_cpol <= wbs_dat_i[CTRL_CPOL];
                ctrl_lsb  <= wbs_dat_i[CTRL_LSB_FIRST];
            end
            if (wb_wr && (addr == ADDR_CFG)) cfg_wlen <= wbs_dat_i[4:0];
            // A new overflow in the same cycle as a clear keeps the flag set.
            ovf <= (ovf & ~ovf_clr) | ovf_set;
        end
    end

endmodule

// File: tb/tb_wfg_record_spi.sv
// Scoreboard bench for wfg_record_spi: random SPI frames, expected words
// derived from the transmitted bit order, checked as AXIS beats appear.
module tb_wfg_record_spi;

    localparam int DEPTH = 2;
`ifdef WFG_RECORD_SPI_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0, cyc_i = 1'b0, we_i = 1'b0;
    logic [3:0]  sel = 4'hF;
    logic [31:0] adr_i = '0, dat_i = '0;
    logic        ack;
    logic [31:0] dat_o;
    logic        spi_sclk = 1'b0, spi_cs = 1'b1, spi_sdi = 1'b0;
    logic        tready = 1'b1;
    logic        tvalid;
    logic [31:0] tdata;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];
    bit          exp_ovf = 1'b0;
    int          exp_cnt = 0;
    bit          cur_cpol = 1'b0;

    always #5 clk = ~clk;

    wfg_record_spi #(.FIFO_DEPTH(DEPTH)) dut (
        .wb_clk_i          (clk),
        .wb_rst_i          (rst),
        .wbs_stb_i         (stb),
        .wbs_cyc_i         (cyc_i),
        .wbs_we_i          (we_i),
        .wbs_sel_i         (sel),
        .wbs_adr_i         (adr_i),
        .wbs_dat_i         (dat_i),
        .wbs_ack_o         (ack),
        .wbs_dat_o         (dat_o),
        .spi_sclk_i        (spi_sclk),
        .spi_cs_ni         (spi_cs),
        .spi_sdi_i         (spi_sdi),
        .wfg_axis_tready_i (tready),
        .wfg_axis_tvalid_o (tvalid),
        .wfg_axis_tdata_o  (tdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every handshake must match the oldest outstanding expected word.
    always @(negedge clk) begin
        if (!rst && tvalid && tready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL axis_unexpected actual=%h expected=none", tdata);
            end else begin
                check("axis_beat", tdata, exp_q.pop_front());
            end
        end
    end

    task automatic wb_access(input bit we, input logic [3:0] a, input logic [31:0] wd,
                             output logic [31:0] rd);
        int n = 0;
        rd = '0;
        stb = 1'b1; cyc_i = 1'b1; we_i = we; adr_i = {28'b0, a}; dat_i = wd;
        @(negedge clk);
        while (!ack && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!ack) begin
            tests++;
            fails++;
            $display("FAIL wb_ack_timeout actual=0 expected=1 adr=%h", a);
        end else begin
            rd = dat_o;
        end
        // Request still held across the ack cycle: ack must not repeat.
        @(posedge clk); #1;
        check("wb_ack_single", {31'b0, ack}, 32'd0);
        stb = 1'b0; cyc_i = 1'b0; we_i = 1'b0;
        tick(1);
    endtask

    task automatic wb_write(input logic [3:0] a, input logic [31:0] wd);
        logic [31:0] dummy;
        wb_access(1'b1, a, wd, dummy);
    endtask

    task automatic rd_check(input logic [3:0] a, input logic [31:0] exp, input string name);
        logic [31:0] v;
        wb_access(1'b0, a, '0, v);
        check(name, v, exp);
    endtask

    task automatic spi_bit(input bit b);
        spi_sdi = b;
        tick(4);
        spi_sclk = ~cur_cpol;
        tick(4);
        spi_sclk = cur_cpol;
    endtask

    task automatic cs_low();
        spi_cs = 1'b0;
        tick(4);
    endtask

    task automatic cs_high();
        tick(4);
        spi_cs = 1'b1;
        tick(8);
    endtask

    // Reference: bits leave in wire order; the received value is rebuilt
    // arithmetically from that order, then kept or dropped by FIFO room.
    task automatic send_word(input int wlen, input bit lsb, input logic [31:0] pattern);
        bit          bits[$];
        logic [31:0] val = '0;
        for (int i = 0; i <= wlen; i++) begin
            bits.push_back(lsb ? pattern[i] : pattern[wlen - i]);
        end
        for (int i = 0; i <= wlen; i++) begin
            if (lsb) val = val + (32'(bits[i]) << i);
            else     val = val * 2 + 32'(bits[i]);
        end
        if (exp_q.size() < DEPTH) begin
            exp_q.push_back(val);
            exp_cnt++;
        end else begin
            exp_ovf = 1'b1;
        end
        foreach (bits[i]) spi_bit(bits[i]);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            tick(1);
            n++;
        end
        check("drain_outstanding", 32'(exp_q.size()), 32'd0);
    endtask

    function automatic logic [31:0] exp_status();
        return {28'b0, 2'(exp_q.size()), 1'b0, exp_ovf};
    endfunction

    initial begin
        int nw, wl;
        bit lsb, cp;

        rst = 1'b1;
        tick(3);
        check("rst_tvalid", {31'b0, tvalid}, 32'd0);
        check("rst_tdata", tdata, 32'd0);
        check("rst_ack", {31'b0, ack}, 32'd0);
        check("rst_dat", dat_o, 32'd0);
        rst = 1'b0;
        tick(1);
        rd_check(4'h0, 32'h0, "rst_ctrl");
        rd_check(4'h4, 32'h1F, "rst_cfg");
        rd_check(4'h8, 32'h0, "rst_status");
        rd_check(4'hC, 32'h0, "rst_cnt");

        // Mode 0, 32-bit, MSB-first
        wb_write(4'h4, 32'd31);
        wb_write(4'h0, 32'h1);
        cs_low();
        send_word(31, 1'b0, 32'hDEADBEEF);
        cs_high();
        drain();
        rd_check(4'hC, CNT_EN ? 32'(exp_cnt) : 32'd0, "cnt_after_first");

        // 8-bit LSB-first: wire bits 1,0,1,1,0,0,0,0
        wb_write(4'h4, 32'd7);
        wb_write(4'h0, 32'h5);
        cs_low();
        send_word(7, 1'b1, 32'h0000000D);
        cs_high();
        drain();

        // Overflow: three bytes into a two-entry FIFO with no consumer
        tready = 1'b0;
        wb_write(4'h0, 32'h1);
        cs_low();
        send_word(7, 1'b0, 32'h11);
        send_word(7, 1'b0, 32'h22);
        send_word(7, 1'b0, 32'h33);
        cs_high();
        check("ovf_model", {31'b0, exp_ovf}, 32'd1);
        rd_check(4'h8, exp_status(), "status_ovf");
        wb_write(4'h8, 32'h1);
        exp_ovf = 1'b0;
        rd_check(4'h8, exp_status(), "status_ovf_clr");
        tready = 1'b1;
        drain();

        // Aborted frame then a clean one
        wb_write(4'h4, 32'd31);
        cs_low();
        for (int i = 0; i < 5; i++) spi_bit(1'($urandom_range(0, 1)));
        cs_high();
        rd_check(4'h8, 32'h0, "status_after_abort");
        check("abort_no_beat", {31'b0, tvalid}, 32'd0);
        cs_low();
        send_word(31, 1'b0, 32'h12345678);
        cs_high();
        drain();

        // CPOL=1, idle high
        wb_write(4'h0, 32'h3);
        cur_cpol = 1'b1;
        spi_sclk = 1'b1;
        tick(4);
        wb_write(4'h4, 32'd7);
        cs_low();
        send_word(7, 1'b0, 32'hA5);
        cs_high();
        drain();

        // Randomized frames
        for (int f = 0; f < 6; f++) begin
            cp  = 1'($urandom_range(0, 1));
            lsb = 1'($urandom_range(0, 1));
            wl  = int'($urandom_range(3, 31));
            nw  = int'($urandom_range(1, 3));
            wb_write(4'h4, 32'(wl));
            wb_write(4'h0, {29'b0, lsb, cp, 1'b1});
            cur_cpol = cp;
            spi_sclk = cp;
            tick(4);
            cs_low();
            for (int w = 0; w < nw; w++) send_word(wl, lsb, $urandom);
            cs_high();
            drain();
        end
        rd_check(4'h8, 32'h0, "status_after_random");
        rd_check(4'hC, CNT_EN ? 32'(exp_cnt) : 32'd0, "cnt_after_random");

        // Reset mid-frame with one word parked in the FIFO
        wb_write(4'h0, 32'h1);
        cur_cpol = 1'b0;
        spi_sclk = 1'b0;
        wb_write(4'h4, 32'd7);
        tready = 1'b0;
        tick(4);
        cs_low();
        for (int i = 0; i < 8; i++) spi_bit(1'($urandom_range(0, 1)));
        tick(6);
        check("pre_rst_tvalid", {31'b0, tvalid}, 32'd1);
        for (int i = 0; i < 3; i++) spi_bit(1'($urandom_range(0, 1)));
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("post_rst_tvalid", {31'b0, tvalid}, 32'd0);
        check("post_rst_tdata", tdata, 32'd0);
        spi_cs = 1'b1;
        tick(4);
        rd_check(4'h0, 32'h0, "post_rst_ctrl");
        rd_check(4'h4, 32'h1F, "post_rst_cfg");
        rd_check(4'h8, 32'h0, "post_rst_status");
        tready = 1'b1;
        tick(10);
        check("end_tvalid", {31'b0, tvalid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
